tpu_tile_ctrl: RTL and testbench
================================

Name: tpu_tile_ctrl

Overview:
Top-level sequencer for the 4x4 systolic-array matmul datapath. It accepts a C[MxN] = A[MxK] x B[KxN] job and walks 4x4 output tiles. For each tile it clears the array, streams K A/B buffer reads, waits for the skewed pipeline to drain, then writes the tile's rows into the C buffer. It sits between the host handshake (in_valid/busy) and the A/B/C global buffers plus the systolic-array feed/row-select logic.

Parameters:
SA_DIM, 4, systolic array dimension (rows = cols)
ADDR_BITS, 16, buffer index width
DRAIN_CYCLES, 7, cycles from last feed until all PE results are valid (2*SA_DIM-1)

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  job start strobe; sampled only in IDLE
K  in  8  inner dimension
M  in  8  rows of A/C
N  in  8  columns of B/C
busy  out  1  high from the cycle after job accept through DONE
done  out  1  one-cycle pulse in DONE
sa_rst  out  1  clears array accumulators; high for the single CLR cycle of each tile
feed_en  out  1  A_index/B_index valid (buffer read request)
A_index  out  ADDR_BITS  A buffer read address
B_index  out  ADDR_BITS  B buffer read address
ld_en  out  1  feed_en delayed one cycle; datapath latches buffer read data
sa_row_sel  out  log2(SA_DIM)  array result row routed to C_data_in
C_wr_en  out  1  C buffer write strobe
C_index  out  ADDR_BITS  C buffer write address

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs and counters go to 0 immediately.
- Reset asserted mid-job aborts the job. There is no done pulse and no further writes.
- States: IDLE, CLR, FEED, DRAIN, WRITE, DONE.
- IDLE:
  - On in_valid=1, latch K/M/N and clear tile counters (mt=0, nt=0).
  - If any of K/M/N is 0, go to DONE. Otherwise go to CLR.
  - in_valid is ignored in every state other than IDLE.
- CLR (1 cycle): sa_rst=1, k=0, then FEED.
- FEED (K cycles):
  - feed_en=1.
  - A_index = mt*K + k. Each A word holds rows 4mt..4mt+3 at column k.
  - B_index = nt*K + k. Each B word holds row k at columns 4nt..4nt+3.
  - k increments each cycle. After k=K-1, go to DRAIN.
- ld_en equals feed_en registered, so it is high for K cycles starting with the second FEED cycle. Its last cycle is the first DRAIN cycle.
- DRAIN: DRAIN_CYCLES cycles with a down-counter, then WRITE with r=0.
- WRITE (always SA_DIM cycles):
  - sa_row_sel=r.
  - C_wr_en=1 only when 4mt+r < M. Rows past M in a partial tile are not written.
  - C_index = nt*M + 4mt + r.
  - Columns past N in a partial tile are still written with zero-padded data. The host ignores them.
  - After r=SA_DIM-1:
    - if mt < ceil(M/4)-1: mt++, go to CLR
    - else if nt < ceil(N/4)-1: mt=0, nt++, go to CLR
    - else go to DONE
- DONE (1 cycle): done=1, busy=1, then IDLE. in_valid in the following cycle is accepted.
- Per-tile cost: 1 + K + DRAIN_CYCLES + SA_DIM cycles. busy time = tiles*(12+K)+1 at defaults.
- Index arithmetic uses running base accumulators, not multipliers:
  - A base adds K per mt step and resets per nt step.
  - B base adds K per nt step.
  - C base adds M per nt step.
- Maximum index is 63*255+255, which fits in 16 bits. No wrap handling is needed.
- All address/strobe outputs are registered. Outputs not named for a state are 0 in that state.

Decomposition:
- Package tpu_pkg: state enum (IDLE..DONE), SA_DIM, ADDR_BITS, DRAIN_CYCLES, and a ceil-div-by-SA_DIM helper function.
- One natural sub-module, tile_index_gen. It holds the mt/nt/k/r counters and the A/B/C base accumulators, driven by step strobes from the FSM.

Test Plan:
1. M=N=K=4, in_valid pulse -> busy 16 cycles then done for 1 cycle. A_index and B_index run 0,1,2,3. C_wr_en fires 4 times with C_index 0..3 and sa_row_sel 0..3.
2. M=8, N=4, K=3 -> two tiles with sa_rst twice. Tile1 A_index is 3,4,5 and B_index is 0,1,2. C_index runs 0..3 then 4..7.
3. M=5, N=6, K=2 -> 4 tiles in order (mt0,nt0),(mt1,nt0),(mt0,nt1),(mt1,nt1). C_index sequence is 0,1,2,3 | 4 | 5,6,7,8 | 9. For the partial tiles, C_wr_en is low for r=1..3.
4. K=0, M=4, N=4 -> IDLE, DONE, IDLE. done pulses on the cycle after accept. No feed_en, sa_rst, or C_wr_en.
5. in_valid held high during a job -> ignored; the job is restarted only if in_valid is still high in the IDLE cycle after DONE. rst_n low mid-FEED -> all outputs 0 asynchronously, IDLE, no done.
6. ld_en/feed_en alignment, K=5 -> ld_en high exactly 5 cycles, each 1 cycle after the matching feed_en. The last ld_en coincides with the first DRAIN cycle.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and constants for the systolic-array tile sequencer.
//   state_t      - sequencer FSM states
//   SA_DIM       - systolic array dimension (rows = cols)
//   ADDR_BITS    - A/B/C buffer index width
//   DRAIN_CYCLES - cycles from last feed until every PE result is valid
//   ceil_div_sa  - number of SA_DIM-wide tiles needed to cover a dimension
package tpu_pkg;

    localparam int SA_DIM       = 4;
    localparam int ADDR_BITS    = 16;
    localparam int DRAIN_CYCLES = 2 * SA_DIM - 1;
    localparam int ROW_BITS     = $clog2(SA_DIM);
    localparam int DRAIN_BITS   = $clog2(DRAIN_CYCLES);
    localparam int DIM_BITS     = 8;
    localparam int TILE_BITS    = DIM_BITS - ROW_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic logic [DIM_BITS-1:0] ceil_div_sa(input logic [DIM_BITS-1:0] x);
        logic [DIM_BITS:0] sum;
        sum = {1'b0, x} + (DIM_BITS+1)'(SA_DIM - 1);
        return DIM_BITS'(sum / (DIM_BITS+1)'(SA_DIM));
    endfunction

endpackage

// File: rtl/tile_index_gen.sv
// tile_index_gen: tile counters and buffer address generation.
// Holds the mt/nt tile counters, the k feed counter and the r write-row
// counter, plus running A/B/C base accumulators so no multipliers are needed.
// All address/strobe outputs are registered and are zero outside their phase.
//   clk, rst_n              - clock, async active-low reset
//   start                   - job accepted: latch dims, clear tile counters
//   k_dim, m_dim, n_dim     - job dimensions (sampled on start)
//   load_feed, feed_step    - CLR cycle / each FEED cycle
//   load_write, write_step  - last DRAIN cycle / each WRITE cycle
//   k_last, r_last          - final FEED / WRITE cycle of a tile
//   last_tile               - current tile is the last of the job
//   A_index, B_index        - A/B buffer read addresses
//   C_index, C_wr_en        - C buffer write address / strobe
//   sa_row_sel              - array row routed to the C buffer
module tile_index_gen
    import tpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DIM_BITS-1:0]  k_dim,
    input  logic [DIM_BITS-1:0]  m_dim,
    input  logic [DIM_BITS-1:0]  n_dim,
    input  logic                 load_feed,
    input  logic                 feed_step,
    input  logic                 load_write,
    input  logic                 write_step,
    output logic                 k_last,
    output logic                 r_last,
    output logic                 last_tile,
    output logic [ADDR_BITS-1:0] A_index,
    output logic [ADDR_BITS-1:0] B_index,
    output logic [ADDR_BITS-1:0] C_index,
    output logic                 C_wr_en,
    output logic [ROW_BITS-1:0]  sa_row_sel
);

    logic [DIM_BITS-1:0]  job_k;
    logic [DIM_BITS-1:0]  job_m;
    logic [TILE_BITS-1:0] mt;
    logic [TILE_BITS-1:0] nt;
    logic [TILE_BITS-1:0] mt_max;
    logic [TILE_BITS-1:0] nt_max;
    logic [DIM_BITS-1:0]  k_cnt;
    logic [ROW_BITS-1:0]  r_cnt;
    logic [DIM_BITS-1:0]  row_base;   // 4*mt, kept as a running sum
    logic [ADDR_BITS-1:0] a_base;
    logic [ADDR_BITS-1:0] b_base;
    logic [ADDR_BITS-1:0] c_base;
    logic [ROW_BITS-1:0]  r_nxt;
    logic [DIM_BITS:0]    row_nxt;

    assign k_last    = (k_cnt == job_k - DIM_BITS'(1));
    assign r_last    = (r_cnt == ROW_BITS'(SA_DIM - 1));
    assign last_tile = (mt == mt_max) && (nt == nt_max);

    always_comb begin
        r_nxt   = r_cnt + ROW_BITS'(1);
        row_nxt = {1'b0, row_base} + (DIM_BITS+1)'(r_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_k      <= '0;
            job_m      <= '0;
            mt         <= '0;
            nt         <= '0;
            mt_max     <= '0;
            nt_max     <= '0;
            k_cnt      <= '0;
            r_cnt      <= '0;
            row_base   <= '0;
            a_base     <= '0;
            b_base     <= '0;
            c_base     <= '0;
            A_index    <= '0;
            B_index    <= '0;
            C_index    <= '0;
            C_wr_en    <= 1'b0;
            sa_row_sel <= '0;
        end else begin
            if (start) begin
                job_k    <= k_dim;
                job_m    <= m_dim;
                mt       <= '0;
                nt       <= '0;
                mt_max   <= TILE_BITS'(ceil_div_sa(m_dim) - DIM_BITS'(1));
                nt_max   <= TILE_BITS'(ceil_div_sa(n_dim) - DIM_BITS'(1));
                row_base <= '0;
                a_base   <= '0;
                b_base   <= '0;
                c_base   <= '0;
            end

            // Addresses are preloaded in CLR so the first FEED cycle
            // already presents k=0 from a register.
            if (load_feed) begin
                k_cnt   <= '0;
                A_index <= a_base;
                B_index <= b_base;
            end else if (feed_step) begin
                k_cnt <= k_cnt + DIM_BITS'(1);
                if (k_last) begin
                    A_index <= '0;
                    B_index <= '0;
                end else begin
                    A_index <= A_index + ADDR_BITS'(1);
                    B_index <= B_index + ADDR_BITS'(1);
                end
            end

            if (load_write) begin
                r_cnt      <= '0;
                sa_row_sel <= '0;
                C_index    <= c_base + ADDR_BITS'(row_base);
                C_wr_en    <= (row_base < job_m);
            end else if (write_step) begin
                if (!r_last) begin
                    r_cnt      <= r_nxt;
                    sa_row_sel <= r_nxt;
                    C_index    <= C_index + ADDR_BITS'(1);
                    C_wr_en    <= (row_nxt < {1'b0, job_m});
                end else begin
                    r_cnt      <= '0;
                    sa_row_sel <= '0;
                    C_index    <= '0;
                    C_wr_en    <= 1'b0;
                    // Tile walk: mt inner, nt outer.
                    if (mt != mt_max) begin
                        mt       <= mt + TILE_BITS'(1);
                        row_base <= row_base + DIM_BITS'(SA_DIM);
                        a_base   <= a_base + ADDR_BITS'(job_k);
                    end else if (nt != nt_max) begin
                        mt       <= '0;
                        nt       <= nt + TILE_BITS'(1);
                        row_base <= '0;
                        a_base   <= '0;
                        b_base   <= b_base + ADDR_BITS'(job_k);
                        c_base   <= c_base + ADDR_BITS'(job_m);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tpu_tile_ctrl.sv
// tpu_tile_ctrl: top-level sequencer for the 4x4 systolic-array matmul.
// Walks 4x4 output tiles of C = A x B: clear, K feed cycles, drain, write rows.
//   clk, rst_n        - clock, async active-low reset
//   in_valid, K, M, N - job start strobe (IDLE only) and dimensions
//   busy, done        - job in progress / one-cycle completion pulse
//   sa_rst            - clear array accumulators (CLR cycle)
//   feed_en, ld_en    - buffer read request / read data latch (feed_en + 1)
//   A_index, B_index  - A/B buffer read addresses
//   sa_row_sel        - array result row routed to C data
//   C_wr_en, C_index  - C buffer write strobe / address
module tpu_tile_ctrl
    import tpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           K,
    input  logic [7:0]           M,
    input  logic [7:0]           N,
    output logic                 busy,
    output logic                 done,
    output logic                 sa_rst,
    output logic                 feed_en,
    output logic [ADDR_BITS-1:0] A_index,
    output logic [ADDR_BITS-1:0] B_index,
    output logic                 ld_en,
    output logic [ROW_BITS-1:0]  sa_row_sel,
    output logic                 C_wr_en,
    output logic [ADDR_BITS-1:0] C_index
);

    state_t                state;
    state_t                nxt_state;
    logic [DRAIN_BITS-1:0] drain_cnt;
    logic                  start;
    logic                  load_feed;
    logic                  feed_step;
    logic                  load_write;
    logic                  write_step;
    logic                  k_last;
    logic                  r_last;
    logic                  last_tile;

    always_comb begin
        nxt_state  = state;
        start      = 1'b0;
        load_feed  = 1'b0;
        feed_step  = 1'b0;
        load_write = 1'b0;
        write_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    start     = 1'b1;
                    nxt_state = (K == '0 || M == '0 || N == '0) ? S_DONE : S_CLR;
                end
            end
            S_CLR: begin
                load_feed = 1'b1;
                nxt_state = S_FEED;
            end
            S_FEED: begin
                feed_step = 1'b1;
                if (k_last) nxt_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    load_write = 1'b1;
                    nxt_state  = S_WRITE;
                end
            end
            S_WRITE: begin
                write_step = 1'b1;
                if (r_last) nxt_state = last_tile ? S_DONE : S_CLR;
            end
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sa_rst    <= 1'b0;
            feed_en   <= 1'b0;
            ld_en     <= 1'b0;
        end else begin
            state   <= nxt_state;
            busy    <= (nxt_state != S_IDLE);
            done    <= (nxt_state == S_DONE);
            sa_rst  <= (nxt_state == S_CLR);
            feed_en <= (nxt_state == S_FEED);
            ld_en   <= feed_en;
            if (state == S_FEED && k_last)
                drain_cnt <= DRAIN_BITS'(DRAIN_CYCLES - 1);
            else if (state == S_DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - DRAIN_BITS'(1);
        end
    end

    tile_index_gen u_index_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .k_dim      (K),
        .m_dim      (M),
        .n_dim      (N),
        .load_feed  (load_feed),
        .feed_step  (feed_step),
        .load_write (load_write),
        .write_step (write_step),
        .k_last     (k_last),
        .r_last     (r_last),
        .last_tile  (last_tile),
        .A_index    (A_index),
        .B_index    (B_index),
        .C_index    (C_index),
        .C_wr_en    (C_wr_en),
        .sa_row_sel (sa_row_sel)
    );

endmodule

// File: tb/tb_tpu_tile_ctrl.sv
// tb_tpu_tile_ctrl: directed self-checking bench for tpu_tile_ctrl.
// Each job is captured cycle by cycle (index 0 = first cycle after accept)
// and compared against hand-computed sequences and cycle positions.
module tb_tpu_tile_ctrl;
    import tpu_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic [7:0]           K, M, N;
    logic                 busy, done, sa_rst, feed_en, ld_en, C_wr_en;
    logic [ADDR_BITS-1:0] A_index, B_index, C_index;
    logic [ROW_BITS-1:0]  sa_row_sel;

    tpu_tile_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .K          (K),
        .M          (M),
        .N          (N),
        .busy       (busy),
        .done       (done),
        .sa_rst     (sa_rst),
        .feed_en    (feed_en),
        .A_index    (A_index),
        .B_index    (B_index),
        .ld_en      (ld_en),
        .sa_row_sel (sa_row_sel),
        .C_wr_en    (C_wr_en),
        .C_index    (C_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy, done, sa_rst, feed_en, ld_en, wr;
        logic [15:0] a, b, c;
        logic [1:0]  rs;
    } smp_t;
    typedef logic [31:0] vq_t[$];

    localparam int unsigned SEL_A = 0, SEL_B = 1, SEL_C = 2, SEL_RS = 3;
    localparam int unsigned CNT_SARST = 0, CNT_FEED = 1, CNT_LD = 2,
                            CNT_WR = 3, CNT_DONE = 4, CNT_BUSY = 5;

    smp_t tr[$];
    int   done_idx;
    int   vectors = 0;
    int   miscompares = 0;
    vq_t  e;
    int   nbusy, ndone;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic smp_t at(input int i);
        smp_t z;
        z = '{default: '0};
        if (i >= 0 && i < tr.size()) return tr[i];
        return z;
    endfunction

    function automatic vq_t pick(input int unsigned sel);
        vq_t q;
        foreach (tr[i]) begin
            case (sel)
                SEL_A:   if (tr[i].feed_en) q.push_back(32'(tr[i].a));
                SEL_B:   if (tr[i].feed_en) q.push_back(32'(tr[i].b));
                SEL_C:   if (tr[i].wr)      q.push_back(32'(tr[i].c));
                SEL_RS:  if (tr[i].wr)      q.push_back(32'(tr[i].rs));
                default: ;
            endcase
        end
        return q;
    endfunction

    function automatic int cnt(input int unsigned sel);
        int n;
        n = 0;
        foreach (tr[i]) begin
            case (sel)
                CNT_SARST: n += int'(tr[i].sa_rst);
                CNT_FEED:  n += int'(tr[i].feed_en);
                CNT_LD:    n += int'(tr[i].ld_en);
                CNT_WR:    n += int'(tr[i].wr);
                CNT_DONE:  n += int'(tr[i].done);
                CNT_BUSY:  n += int'(tr[i].busy);
                default:   ;
            endcase
        end
        return n;
    endfunction

    task automatic chk_q(input string tag, input vq_t got, input vq_t exp);
        chk({tag, ".len"}, 32'(got.size()), 32'(exp.size()));
        for (int unsigned i = 0; i < unsigned'(exp.size()) && i < unsigned'(got.size()); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic start_job(input logic [7:0] k, input logic [7:0] m,
                             input logic [7:0] n, input bit hold);
        @(negedge clk);
        K = k; M = m; N = n;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic capture(input int budget);
        smp_t s;
        tr.delete();
        done_idx = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            s.busy = busy;   s.done = done;   s.sa_rst = sa_rst;
            s.feed_en = feed_en; s.ld_en = ld_en; s.wr = C_wr_en;
            s.a = A_index;   s.b = B_index;   s.c = C_index;
            s.rs = sa_row_sel;
            tr.push_back(s);
            if (done === 1'b1) begin
                done_idx = i;
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},    32'(busy),       0);
        chk({tag, ".done"},    32'(done),       0);
        chk({tag, ".sa_rst"},  32'(sa_rst),     0);
        chk({tag, ".feed_en"}, 32'(feed_en),    0);
        chk({tag, ".ld_en"},   32'(ld_en),      0);
        chk({tag, ".C_wr_en"}, 32'(C_wr_en),    0);
        chk({tag, ".A_index"}, 32'(A_index),    0);
        chk({tag, ".B_index"}, 32'(B_index),    0);
        chk({tag, ".C_index"}, 32'(C_index),    0);
        chk({tag, ".row_sel"}, 32'(sa_row_sel), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; K = '0; M = '0; N = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Job 1: single full tile, K=M=N=4.
        start_job(8'd4, 8'd4, 8'd4, 1'b0);
        capture(60);
        chk("t1.done_idx", 32'(done_idx), 16);
        chk("t1.busy_cnt", 32'(cnt(CNT_BUSY)), 17);
        chk("t1.done_cnt", 32'(cnt(CNT_DONE)), 1);
        chk("t1.sarst_cnt", 32'(cnt(CNT_SARST)), 1);
        chk("t1.sarst_at0", 32'(at(0).sa_rst), 1);
        e = '{0, 1, 2, 3}; chk_q("t1.A", pick(SEL_A), e);
        e = '{0, 1, 2, 3}; chk_q("t1.B", pick(SEL_B), e);
        e = '{0, 1, 2, 3}; chk_q("t1.C", pick(SEL_C), e);
        e = '{0, 1, 2, 3}; chk_q("t1.RS", pick(SEL_RS), e);
        chk("t1.wr_at12", 32'(at(12).wr), 1);
        @(negedge clk);
        chk("t1.idle_busy", 32'(busy), 0);
        chk("t1.idle_done", 32'(done), 0);

        // Job 2: M=8, N=4, K=3 -> two row tiles.
        start_job(8'd3, 8'd8, 8'd4, 1'b0);
        capture(80);
        chk("t2.done_idx", 32'(done_idx), 30);
        chk("t2.sarst_cnt", 32'(cnt(CNT_SARST)), 2);
        chk("t2.sarst_at15", 32'(at(15).sa_rst), 1);
        e = '{0, 1, 2, 3, 4, 5}; chk_q("t2.A", pick(SEL_A), e);
        e = '{0, 1, 2, 0, 1, 2}; chk_q("t2.B", pick(SEL_B), e);
        e = '{0, 1, 2, 3, 4, 5, 6, 7}; chk_q("t2.C", pick(SEL_C), e);
        e = '{0, 1, 2, 3, 0, 1, 2, 3}; chk_q("t2.RS", pick(SEL_RS), e);

        // Job 3: M=5, N=6, K=2 -> four tiles, two partial in rows.
        start_job(8'd2, 8'd5, 8'd6, 1'b0);
        capture(120);
        chk("t3.done_idx", 32'(done_idx), 56);
        chk("t3.sarst_cnt", 32'(cnt(CNT_SARST)), 4);
        e = '{0, 1, 2, 3, 0, 1, 2, 3}; chk_q("t3.A", pick(SEL_A), e);
        e = '{0, 1, 0, 1, 2, 3, 2, 3}; chk_q("t3.B", pick(SEL_B), e);
        e = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}; chk_q("t3.C", pick(SEL_C), e);
        chk("t3.wr_at24", 32'(at(24).wr), 1);
        chk("t3.c_at24",  32'(at(24).c), 4);
        chk("t3.wr_at25", 32'(at(25).wr), 0);
        chk("t3.rs_at25", 32'(at(25).rs), 1);
        chk("t3.c_at25",  32'(at(25).c), 5);
        chk("t3.wr_at27", 32'(at(27).wr), 0);
        chk("t3.rs_at27", 32'(at(27).rs), 3);
        chk("t3.c_at52",  32'(at(52).c), 9);
        chk("t3.wr_at53", 32'(at(53).wr), 0);
        chk("t3.c_at53",  32'(at(53).c), 10);

        // Job 4: K=0 -> straight to DONE.
        start_job(8'd0, 8'd4, 8'd4, 1'b0);
        capture(10);
        chk("t4.done_idx", 32'(done_idx), 0);
        chk("t4.busy_at0", 32'(at(0).busy), 1);
        chk("t4.feed_cnt", 32'(cnt(CNT_FEED)), 0);
        chk("t4.sarst_cnt", 32'(cnt(CNT_SARST)), 0);
        chk("t4.wr_cnt", 32'(cnt(CNT_WR)), 0);
        @(negedge clk);
        chk("t4.idle_busy", 32'(busy), 0);
        chk("t4.idle_done", 32'(done), 0);

        // Job 6: ld_en alignment with K=5.
        start_job(8'd5, 8'd4, 8'd4, 1'b0);
        capture(60);
        chk("t6.done_idx", 32'(done_idx), 17);
        chk("t6.feed_cnt", 32'(cnt(CNT_FEED)), 5);
        chk("t6.ld_cnt", 32'(cnt(CNT_LD)), 5);
        chk("t6.ld_at1", 32'(at(1).ld_en), 0);
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("t6.feed_at%0d", i), 32'(at(i).feed_en), 1);
            chk($sformatf("t6.ld_at%0d", i + 1), 32'(at(i + 1).ld_en), 1);
        end
        chk("t6.feed_at6", 32'(at(6).feed_en), 0);
        chk("t6.ld_at7", 32'(at(7).ld_en), 0);

        // Job 5: in_valid held high, then reset in the middle of FEED.
        start_job(8'd4, 8'd4, 8'd4, 1'b1);
        capture(60);
        chk("t5.done_idx", 32'(done_idx), 16);
        chk("t5.sarst_cnt", 32'(cnt(CNT_SARST)), 1);
        @(negedge clk);
        chk("t5.idle_busy", 32'(busy), 0);
        @(negedge clk);
        chk("t5.restart_busy", 32'(busy), 1);
        chk("t5.restart_sarst", 32'(sa_rst), 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5.feed0_en", 32'(feed_en), 1);
        chk("t5.feed0_A", 32'(A_index), 0);
        @(negedge clk);
        chk("t5.feed1_A", 32'(A_index), 1);
        chk("t5.feed1_B", 32'(B_index), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5.abort");
        @(negedge clk);
        rst_n = 1'b1;
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            nbusy += int'(busy);
            ndone += int'(done);
        end
        chk("t5.post_busy", 32'(nbusy), 0);
        chk("t5.post_done", 32'(ndone), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
